conv_psum_post: RTL and testbench

Output post-processing stage directly downstream of the convolution PE. It accumulates the PE's Tout partial sums across all input-channel tiles of an output row using an on-chip row buffer. On the final tile it adds a per-lane bias, requantizes with a rounding arithmetic right shift, applies an activation and saturates to 8-bit. The packed Tout-byte result feeds the output feature-map writer.

---
 rtl/conv_psum_post.sv | 180 ++++++++++++++++++
 tb/tb_conv_psum_post.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_post.sv
// Post-processing stage behind the convolution PE.
// It accumulates partial sums across input-channel tiles, then applies bias, rounding shift, activation and int8 saturation.
module conv_psum_post #(
  parameter int Tout      = 4,
  parameter int W_PSUM    = 32,
  parameter int W_DATA    = 8,
  parameter int W_BIAS    = 16,
  parameter int W_SIZE    = 10,
  parameter int W_CHANNEL = 10,
  parameter int MAX_W     = 512
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_cfg_start,
  input  logic [W_SIZE-1:0]         cfg_width,
  input  logic [W_CHANNEL-1:0]      cfg_ntile,
  input  logic [4:0]                cfg_shift,
  input  logic [1:0]                cfg_act,
  input  logic                      i_bias_we,
  input  logic [Tout*W_BIAS-1:0]    i_bias,
  input  logic [Tout*W_PSUM-1:0]    i_acc,
  input  logic                      i_vld,
  output logic [Tout*W_DATA-1:0]    o_data,
  output logic                      o_vld,
  output logic                      o_row_done
);

  localparam int ADDR_W = $clog2(MAX_W);
  localparam logic signed [W_PSUM:0] PSUM_MAX = {2'b00, {(W_PSUM-1){1'b1}}};
  localparam logic signed [W_PSUM:0] PSUM_MIN = {2'b11, {(W_PSUM-1){1'b0}}};
  localparam logic signed [W_PSUM:0] DATA_MAX = {{(W_PSUM-W_DATA+2){1'b0}}, {(W_DATA-1){1'b1}}};
  localparam logic signed [W_PSUM:0] DATA_MIN = {{(W_PSUM-W_DATA+2){1'b1}}, {(W_DATA-1){1'b0}}};
  localparam logic signed [W_PSUM:0] ONE      = 1;

  function automatic logic [W_PSUM-1:0] sat_psum(input logic signed [W_PSUM:0] v);
    if (v > PSUM_MAX)      return PSUM_MAX[W_PSUM-1:0];
    else if (v < PSUM_MIN) return PSUM_MIN[W_PSUM-1:0];
    else                   return v[W_PSUM-1:0];
  endfunction

  // Configuration and counters
  logic [W_SIZE-1:0]      r_width;
  logic [W_CHANNEL-1:0]   r_ntile;
  logic [4:0]             r_shift;
  logic [1:0]             r_act;
  logic [W_SIZE-1:0]      r_col;
  logic [W_CHANNEL-1:0]   r_tile;
  logic [Tout*W_BIAS-1:0] r_bias;
  logic [Tout*W_PSUM-1:0] r_psum_buf [MAX_W];

  logic [W_SIZE-1:0]      w_width_m1;
  logic [W_CHANNEL-1:0]   w_ntile_m1;
  logic                   w_first;
  logic                   w_last;
  logic                   w_col_wrap;
  logic                   w_beat;
  logic [ADDR_W-1:0]      w_addr;
  logic [Tout*W_PSUM-1:0] w_rd;
  logic [Tout*W_PSUM-1:0] w_sum;
  logic [Tout*W_PSUM-1:0] w_b;

  // A zero width or tile count behaves as one.
  assign w_width_m1 = (r_width == '0) ? '0 : r_width - W_SIZE'(1);
  assign w_ntile_m1 = (r_ntile == '0) ? '0 : r_ntile - W_CHANNEL'(1);
  assign w_first    = (r_tile == '0);
  assign w_last     = (r_tile == w_ntile_m1);
  assign w_col_wrap = (r_col == w_width_m1);
  assign w_beat     = i_vld && !i_cfg_start;
  assign w_addr     = r_col[ADDR_W-1:0];
  assign w_rd       = r_psum_buf[w_addr];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_sum = '0;
    for (int t = 0; t < Tout; t++) begin
      w_sum[t*W_PSUM +: W_PSUM] = sat_psum(
        {i_acc[t*W_PSUM+W_PSUM-1], i_acc[t*W_PSUM +: W_PSUM]} +
        (w_first ? '0 : {w_rd[t*W_PSUM+W_PSUM-1], w_rd[t*W_PSUM +: W_PSUM]}));
    end
  end

  always_comb begin
    w_b = '0;
    for (int t = 0; t < Tout; t++) begin
      w_b[t*W_PSUM +: W_PSUM] = sat_psum(
        {w_sum[t*W_PSUM+W_PSUM-1], w_sum[t*W_PSUM +: W_PSUM]} +
        {{(W_PSUM+1-W_BIAS){r_bias[t*W_BIAS+W_BIAS-1]}}, r_bias[t*W_BIAS +: W_BIAS]});
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_width <= '0;
      r_ntile <= '0;
      r_shift <= '0;
      r_act   <= '0;
      r_col   <= '0;
      r_tile  <= '0;
      r_bias  <= '0;
    end else begin
      if (i_bias_we) r_bias <= i_bias;
      if (i_cfg_start) begin
        r_width <= cfg_width;
        r_ntile <= cfg_ntile;
        r_shift <= cfg_shift;
        r_act   <= cfg_act;
        r_col   <= '0;
        r_tile  <= '0;
      end else if (i_vld) begin
        if (w_col_wrap) begin
          r_col  <= '0;
          r_tile <= w_last ? '0 : r_tile + W_CHANNEL'(1);
        end else begin
          r_col  <= r_col + W_SIZE'(1);
        end
      end
    end
  end

  // NOTE: the row buffer has no reset; the first tile always writes before any tile reads.
  always_ff @(posedge clk) begin
    if (w_beat && !w_last) r_psum_buf[w_addr] <= w_sum;
  end

  // Stage 1 carries shift and activation so a restart cannot disturb beats in flight.
  logic                   r_s1_vld;
  logic                   r_s1_done;
  logic [Tout*W_PSUM-1:0] r_s1_b;
  logic [4:0]             r_s1_shift;
  logic [1:0]             r_s1_act;

  logic signed [W_PSUM:0] w_round;
  logic signed [W_PSUM:0] w_b33 [Tout];
  logic signed [W_PSUM:0] w_r   [Tout];
  logic signed [W_PSUM:0] w_act [Tout];
  logic [Tout*W_DATA-1:0] w_data;

  assign w_round = (r_s1_shift == '0) ? '0 : (ONE << (r_s1_shift - 5'd1));

  always_comb begin
    w_data = '0;
    for (int t = 0; t < Tout; t++) begin
      w_b33[t] = {r_s1_b[t*W_PSUM+W_PSUM-1], r_s1_b[t*W_PSUM +: W_PSUM]} + w_round;
      w_r[t]   = w_b33[t] >>> r_s1_shift;
      w_act[t] = w_r[t];
      if (w_r[t][W_PSUM]) begin
        if (r_s1_act == 2'b01)      w_act[t] = '0;
        else if (r_s1_act == 2'b10) w_act[t] = w_r[t] >>> 3;
      end
      if (w_act[t] > DATA_MAX)      w_data[t*W_DATA +: W_DATA] = DATA_MAX[W_DATA-1:0];
      else if (w_act[t] < DATA_MIN) w_data[t*W_DATA +: W_DATA] = DATA_MIN[W_DATA-1:0];
      else                          w_data[t*W_DATA +: W_DATA] = w_act[t][W_DATA-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_vld   <= 1'b0;
      r_s1_done  <= 1'b0;
      r_s1_b     <= '0;
      r_s1_shift <= '0;
      r_s1_act   <= '0;
      o_vld      <= 1'b0;
      o_row_done <= 1'b0;
      o_data     <= '0;
    end else begin
      r_s1_vld <= w_beat && w_last;
      if (w_beat && w_last) begin
        r_s1_b     <= w_b;
        r_s1_done  <= w_col_wrap;
        r_s1_shift <= r_shift;
        r_s1_act   <= r_act;
      end
      o_vld      <= r_s1_vld;
      o_row_done <= r_s1_vld && r_s1_done;
      if (r_s1_vld) o_data <= w_data;
    end
  end

endmodule

// File: tb/tb_conv_psum_post.sv
// Self-checking bench for conv_psum_post: directed scenarios plus randomized rows.
// Every row is checked against a reference model that sums tiles arithmetically.
module tb_conv_psum_post;

  localparam int TOUT = 4;
  localparam int WP   = 32;
  localparam int WD   = 8;
  localparam int WB   = 16;
  localparam int MAXW = 512;
  localparam longint PMAX = 64'sd2147483647;
  localparam longint PMIN = -64'sd2147483648;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 i_cfg_start = 1'b0;
  logic [9:0]           cfg_width = '0;
  logic [9:0]           cfg_ntile = '0;
  logic [4:0]           cfg_shift = '0;
  logic [1:0]           cfg_act = '0;
  logic                 i_bias_we = 1'b0;
  logic [TOUT*WB-1:0]   i_bias = '0;
  logic [TOUT*WP-1:0]   i_acc = '0;
  logic                 i_vld = 1'b0;
  logic [TOUT*WD-1:0]   o_data;
  logic                 o_vld;
  logic                 o_row_done;

  conv_psum_post dut (
    .clk(clk), .rstn(rstn), .i_cfg_start(i_cfg_start),
    .cfg_width(cfg_width), .cfg_ntile(cfg_ntile), .cfg_shift(cfg_shift), .cfg_act(cfg_act),
    .i_bias_we(i_bias_we), .i_bias(i_bias), .i_acc(i_acc), .i_vld(i_vld),
    .o_data(o_data), .o_vld(o_vld), .o_row_done(o_row_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TOUT*WD-1:0] data;
    logic               done;
    int                 due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;

  int psum_arr [4][MAXW][TOUT];
  int m_width, m_ntile, m_shift, m_act;
  int m_bias [TOUT];

  always @(posedge clk) cyc++;

  function automatic longint sat32(input longint v);
    if (v > PMAX) return PMAX;
    if (v < PMIN) return PMIN;
    return v;
  endfunction

  // Reference: bias, rounding shift, activation, int8 clamp using wide arithmetic.
  function automatic int post(input longint s, input longint bias, input int shift, input int act);
    longint b, r;
    b = sat32(s + bias);
    if (shift > 0) r = (b + (longint'(1) << (shift - 1))) >>> shift;
    else           r = b;
    if (r < 0 && act == 1) r = 0;
    if (r < 0 && act == 2) r = r >>> 3;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  function automatic int rnd_psum();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return int'($urandom_range(0, 400000)) - 200000;
      default: return int'($urandom_range(0, 4000)) - 2000;
    endcase
  endfunction

  // Output monitor: each o_vld must match the oldest expected result, on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_vld) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_vld: o_vld=1 o_data=%h o_row_done=%b at cycle %0d, required no output",
                   o_data, o_row_done, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (o_data !== mon_e.data || o_row_done !== mon_e.done || cyc != mon_e.due) begin
            n_errors++;
            $display("FAIL output: o_data=%h o_row_done=%b cycle=%0d, required o_data=%h o_row_done=%b cycle=%0d",
                     o_data, o_row_done, cyc, mon_e.data, mon_e.done, mon_e.due);
          end
        end
      end else begin
        n_checks++;
        if (o_row_done !== 1'b0) begin
          n_errors++;
          $display("FAIL row_done_alone: o_row_done=%b with o_vld=0, required 0", o_row_done);
        end
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          n_errors++;
          mon_e = exp_q.pop_front();
          $display("FAIL missing_vld: o_vld=0 at cycle %0d, required o_data=%h due at cycle %0d",
                   cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  task automatic set_bias();
    @(negedge clk);
    i_bias_we   = 1'b1;
    i_vld       = 1'b0;
    i_cfg_start = 1'b0;
    for (int t = 0; t < TOUT; t++) i_bias[t*WB +: WB] = WB'(m_bias[t]);
    @(negedge clk);
    i_bias_we = 1'b0;
  endtask

  task automatic do_cfg(input int width, input int ntile_raw, input int shift, input int act);
    @(negedge clk);
    i_cfg_start = 1'b1;
    i_vld       = 1'b0;
    cfg_width   = 10'(width);
    cfg_ntile   = 10'(ntile_raw);
    cfg_shift   = 5'(shift);
    cfg_act     = 2'(act);
    m_width = width;
    m_ntile = (ntile_raw == 0) ? 1 : ntile_raw;
    m_shift = shift;
    m_act   = act;
    @(negedge clk);
    i_cfg_start = 1'b0;
  endtask

  task automatic drive_beat(input int tile, input int col);
    exp_t   e;
    longint acc;
    @(negedge clk);
    i_cfg_start = 1'b0;
    i_vld       = 1'b1;
    for (int t = 0; t < TOUT; t++) i_acc[t*WP +: WP] = WP'(psum_arr[tile][col][t]);
    if (tile == m_ntile - 1) begin
      e.data = '0;
      for (int t = 0; t < TOUT; t++) begin
        acc = 0;
        for (int k = 0; k < m_ntile; k++) acc = sat32(acc + longint'(psum_arr[k][col][t]));
        e.data[t*WD +: WD] = WD'(post(acc, longint'(m_bias[t]), m_shift, m_act));
      end
      e.done = (col == m_width - 1);
      e.due  = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic play_row(input bit gaps);
    for (int k = 0; k < m_ntile; k++) begin
      for (int c = 0; c < m_width; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          @(negedge clk);
          i_vld = 1'b0;
        end
        drive_beat(k, c);
      end
    end
  endtask

  task automatic fill_const(input int tile, input int width, input int v);
    for (int c = 0; c < width; c++)
      for (int t = 0; t < TOUT; t++) psum_arr[tile][c][t] = v;
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    i_vld = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int t = 0; t < TOUT; t++) m_bias[t] = 0;
    repeat (3) @(negedge clk);
    n_checks += 3;
    if (o_vld !== 1'b0)      begin n_errors++; $display("FAIL reset_vld: o_vld=%b, required 0", o_vld); end
    if (o_data !== '0)       begin n_errors++; $display("FAIL reset_data: o_data=%h, required 0", o_data); end
    if (o_row_done !== 1'b0) begin n_errors++; $display("FAIL reset_row_done: o_row_done=%b, required 0", o_row_done); end
    rstn   = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_tile();
    for (int t = 0; t < TOUT; t++) m_bias[t] = 28;
    set_bias();
    do_cfg(4, 1, 2, 0);
    fill_const(0, 4, 100);
    play_row(1'b0);
    drain();
  endtask

  task automatic test_three_tile();
    for (int t = 0; t < TOUT; t++) m_bias[t] = 0;
    set_bias();
    do_cfg(3, 3, 0, 0);
    for (int k = 0; k < 3; k++) fill_const(k, 3, 10 * (k + 1));
    play_row(1'b0);
    play_row(1'b0);
    drain();
  endtask

  task automatic one_beat(input int shift, input int act, input int v);
    do_cfg(1, 0, shift, act);
    fill_const(0, 1, v);
    play_row(1'b0);
  endtask

  task automatic test_sat_act();
    one_beat(0, 0, 1000);
    one_beat(0, 0, -1000);
    one_beat(0, 1, -5);
    one_beat(0, 2, -40);
    one_beat(0, 2, -1);
    one_beat(0, 3, -7);
    one_beat(0, 1, 9);
    do_cfg(1, 2, 31, 0);
    fill_const(0, 1, 32'sh7FFFFFF0);
    fill_const(1, 1, 32'sh100);
    play_row(1'b0);
    fill_const(0, 1, -32'sh7FFFFFF0);
    fill_const(1, 1, -32'sh100);
    play_row(1'b0);
    drain();
  endtask

  task automatic test_rounding();
    do_cfg(1, 1, 1, 0);
    fill_const(0, 1, 3);  play_row(1'b0);
    fill_const(0, 1, -3); play_row(1'b0);
    fill_const(0, 1, 1);  play_row(1'b0);
    do_cfg(1, 1, 31, 0);
    fill_const(0, 1, -1); play_row(1'b0);
    drain();
  endtask

  task automatic test_start_collision();
    for (int t = 0; t < TOUT; t++) m_bias[t] = 0;
    set_bias();
    do_cfg(2, 2, 0, 0);
    fill_const(0, 2, 5);
    fill_const(1, 2, 7);
    drive_beat(0, 0);
    drive_beat(0, 1);
    drive_beat(1, 0);
    @(negedge clk);
    i_cfg_start = 1'b1;
    i_vld       = 1'b1;
    for (int t = 0; t < TOUT; t++) i_acc[t*WP +: WP] = WP'(1000);
    for (int c = 0; c < 2; c++)
      for (int t = 0; t < TOUT; t++) begin
        psum_arr[0][c][t] = 40 + c + t;
        psum_arr[1][c][t] = 50 - c - t;
      end
    play_row(1'b0);
    drain();
  endtask

  task automatic test_reset_mid_row();
    do_cfg(3, 2, 0, 0);
    fill_const(0, 3, 100);
    fill_const(1, 3, 11);
    for (int c = 0; c < 3; c++) drive_beat(0, c);
    drive_beat(1, 0);
    drive_beat(1, 1);
    @(negedge clk);
    mon_en = 1'b0;
    rstn   = 1'b0;
    i_vld  = 1'b0;
    #1;
    n_checks += 3;
    if (o_vld !== 1'b0)      begin n_errors++; $display("FAIL midreset_vld: o_vld=%b, required 0", o_vld); end
    if (o_data !== '0)       begin n_errors++; $display("FAIL midreset_data: o_data=%h, required 0", o_data); end
    if (o_row_done !== 1'b0) begin n_errors++; $display("FAIL midreset_row_done: o_row_done=%b, required 0", o_row_done); end
    exp_q.delete();
    for (int t = 0; t < TOUT; t++) m_bias[t] = 0;
    repeat (2) @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;
    do_cfg(3, 2, 1, 1);
    for (int c = 0; c < 3; c++)
      for (int t = 0; t < TOUT; t++) begin
        psum_arr[0][c][t] = -20 * (c + 1) + t;
        psum_arr[1][c][t] = 7 * t - c;
      end
    play_row(1'b0);
    drain();
  endtask

  task automatic test_random();
    int w, nt, sh, act;
    for (int r = 0; r < 24; r++) begin
      for (int t = 0; t < TOUT; t++) m_bias[t] = int'($urandom_range(0, 65535)) - 32768;
      set_bias();
      w   = (r == 23) ? MAXW : int'($urandom_range(1, 20));
      nt  = (r == 23) ? 2 : int'($urandom_range(1, 4));
      sh  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 12));
      act = int'($urandom_range(0, 3));
      do_cfg(w, nt, sh, act);
      for (int k = 0; k < m_ntile; k++)
        for (int c = 0; c < w; c++)
          for (int t = 0; t < TOUT; t++) psum_arr[k][c][t] = rnd_psum();
      play_row(bit'($urandom_range(0, 1)));
      if (r % 3 == 0) play_row(1'b0);
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_three_tile();
    test_sat_act();
    test_rounding();
    test_start_collision();
    test_reset_mid_row();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule
